// File: rtl/network_sel_gen_if.sv
// Control and bank-select bundle between the transform sequencer and the datapath it drives.
interface network_sel_gen_if;
  logic       start;
  logic       mode;
  logic       sel;
  logic       sen;
  logic [1:0] sel_a_0;
  logic [1:0] sel_a_1;
  logic [1:0] sel_a_2;
  logic [1:0] sel_a_3;
  logic [2:0] stage;
  logic       busy;
  logic       done;

  modport master (
    output start, mode,
    input  sel, sen, sel_a_0, sel_a_1, sel_a_2, sel_a_3, stage, busy, done
  );

  modport slave (
    input  start, mode,
    output sel, sen, sel_a_0, sel_a_1, sel_a_2, sel_a_3, stage, busy, done
  );
endinterface

// File: rtl/network_sel_gen.sv
// Stage/cycle sequencer for an (I)NTT pass: walks stages and butterfly cycles, flushes, pulses done.
// Bank-routing selects rotate by (cnt + stage) mod 4 and lag the counters by one cycle.
module network_sel_gen #(
  parameter int data_width = 12,
  parameter int cnt_width  = 6,
  parameter int stage_num  = 7
) (
  input logic               clk,
  input logic               rst,
  network_sel_gen_if.slave  bus
);

  localparam int         unused_data_width = data_width;
  localparam logic [2:0] last_stage        = 3'(stage_num - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t               state_q, state_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic [2:0]           stage_q, stage_d;
  logic [3:0]           flush_q, flush_d;
  logic                 sel_q, sel_d;
  logic                 sen_q, sen_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [3:0][1:0]      sel_a_q, sel_a_d;
  logic [1:0]           rot;
  logic [3:0]           flush_last;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stage_d    = stage_q;
    flush_d    = flush_q;
    sel_d      = sel_q;
    sel_a_d    = sel_a_q;
    rot        = cnt_q[1:0] + stage_q[1:0];
    // INTT needs the longer drain of its extra output scaling stages.
    flush_last = sel_q ? 4'd12 : 4'd6;
    sen_d      = (state_q == RUN) || (state_q == FLUSH);
    busy_d     = (state_q == RUN) || (state_q == FLUSH);
    done_d     = (state_q == DONE);

    if (state_q == RUN) begin
      for (int i = 0; i < 4; i++) begin
        sel_a_d[i] = 2'(i) + rot;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sel_d   = bus.mode;
          cnt_d   = '0;
          stage_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + cnt_width'(1);
        if (&cnt_q) begin
          if (stage_q == last_stage) begin
            state_d = FLUSH;
            flush_d = '0;
          end else begin
            stage_d = stage_q + 3'd1;
          end
        end
      end
      FLUSH: begin
        if (flush_q == flush_last) begin
          state_d = DONE;
        end else begin
          flush_d = flush_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      flush_q <= '0;
      sel_q   <= 1'b0;
      sen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sel_a_q <= {2'd3, 2'd2, 2'd1, 2'd0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      flush_q <= flush_d;
      sel_q   <= sel_d;
      sen_q   <= sen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sel_a_q <= sel_a_d;
    end
  end

  assign bus.sel     = sel_q;
  assign bus.sen     = sen_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.stage   = stage_q;
  assign bus.sel_a_0 = sel_a_q[0];
  assign bus.sel_a_1 = sel_a_q[1];
  assign bus.sel_a_2 = sel_a_q[2];
  assign bus.sel_a_3 = sel_a_q[3];

endmodule

// File: tb/tb_network_sel_gen.sv
// Bench for network_sel_gen: per-cycle expected trace in a scoreboard queue, run/rotation vector tables.
module tb_network_sel_gen;
  localparam int CW    = 6;
  localparam int SN    = 7;
  localparam int NCYC  = SN * (1 << CW);

  typedef struct packed {
    logic       sel;
    logic       sen;
    logic       busy;
    logic       done;
    logic [2:0] stage;
    logic [1:0] a0;
    logic [1:0] a1;
    logic [1:0] a2;
    logic [1:0] a3;
  } obs_t;

  typedef struct {
    logic mode;
    logic tog;
    int   done_n;
    int   busy_n;
  } run_vec_t;

  typedef struct {
    int         stage;
    int         cnt;
    logic [7:0] a;
  } rot_vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  network_sel_gen_if bus ();

  network_sel_gen #(.data_width(12), .cnt_width(CW), .stage_num(SN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         tests = 0;
  int         fails = 0;
  obs_t       exp_q[$];
  logic [7:0] cap[NCYC];
  logic [7:0] last_a;
  run_vec_t   runs[4];
  rot_vec_t   rots[8];
  obs_t       reset_obs;

  function automatic obs_t sample();
    obs_t o;
    o.sel   = bus.sel;
    o.sen   = bus.sen;
    o.busy  = bus.busy;
    o.done  = bus.done;
    o.stage = bus.stage;
    o.a0    = bus.sel_a_0;
    o.a1    = bus.sel_a_1;
    o.a2    = bus.sel_a_2;
    o.a3    = bus.sel_a_3;
    return o;
  endfunction

  task automatic check_obs(input string name, input int n, input obs_t act, input obs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, n, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected outputs for cycles 1..n_end after the edge on which start is sampled.
  task automatic push_trace(input logic m, input logic [7:0] prev_a, input int n_end);
    int flen;
    flen = m ? 13 : 7;
    for (int n = 1; n <= n_end; n++) begin
      obs_t e;
      int   t;
      int   st;
      int   r;
      e.sel  = m;
      e.sen  = (n >= 2) && (n <= NCYC + 1 + flen);
      e.busy = e.sen;
      e.done = (n == NCYC + 2 + flen);
      st = (n - 1) / 64;
      if (st > SN - 1) st = SN - 1;
      e.stage = 3'(st);
      if (n < 2) begin
        {e.a0, e.a1, e.a2, e.a3} = prev_a;
      end else begin
        t = n - 2;
        if (t > NCYC - 1) t = NCYC - 1;
        r = ((t % 64) + (t / 64)) % 4;
        e.a0 = 2'(r % 4);
        e.a1 = 2'((1 + r) % 4);
        e.a2 = 2'((2 + r) % 4);
        e.a3 = 2'((3 + r) % 4);
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic do_run(input logic m, input logic tog, input int exp_done_n,
                        input int exp_busy_n, input int abort_n);
    int   flen;
    int   n_end;
    int   done_cnt;
    int   busy_cnt;
    int   done_n;
    obs_t act;
    obs_t e;
    flen     = m ? 13 : 7;
    n_end    = NCYC + 4 + flen;
    done_cnt = 0;
    busy_cnt = 0;
    done_n   = -1;
    push_trace(m, last_a, n_end);
    bus.start = 1'b1;
    bus.mode  = m;
    for (int n = 1; n <= n_end; n++) begin
      @(posedge clk);
      #1;
      act = sample();
      e   = exp_q.pop_front();
      check_obs("trace", n, act, e);
      last_a = {e.a0, e.a1, e.a2, e.a3};
      if (act.done) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      if (act.busy) busy_cnt++;
      if (n >= 2 && n <= NCYC + 1) cap[n - 2] = {act.a0, act.a1, act.a2, act.a3};
      if (abort_n > 0 && n == abort_n) begin
        rst       = 1'b1;
        bus.start = 1'b0;
        break;
      end
      if (tog && n <= NCYC + 1 + flen) begin
        bus.start = 1'b1;
        bus.mode  = ~bus.mode;
      end else begin
        bus.start = 1'b0;
      end
    end
    exp_q.delete();
    if (abort_n == 0) begin
      check_int("done_pulses", done_cnt, 1);
      check_int("done_cycle", done_n, exp_done_n);
      check_int("busy_cycles", busy_cnt, exp_busy_n);
    end else begin
      check_int("abort_no_done", done_cnt, 0);
    end
  endtask

  initial begin
    int done_seen;
    runs[0] = '{mode: 1'b0, tog: 1'b0, done_n: 457, busy_n: 455};
    runs[1] = '{mode: 1'b1, tog: 1'b0, done_n: 463, busy_n: 461};
    runs[2] = '{mode: 1'b0, tog: 1'b1, done_n: 457, busy_n: 455};
    runs[3] = '{mode: 1'b1, tog: 1'b1, done_n: 463, busy_n: 461};

    rots[0] = '{stage: 1, cnt: 2,  a: 8'b11_00_01_10};
    rots[1] = '{stage: 0, cnt: 63, a: 8'b11_00_01_10};
    rots[2] = '{stage: 1, cnt: 0,  a: 8'b01_10_11_00};
    rots[3] = '{stage: 0, cnt: 0,  a: 8'b00_01_10_11};
    rots[4] = '{stage: 6, cnt: 63, a: 8'b01_10_11_00};
    rots[5] = '{stage: 3, cnt: 1,  a: 8'b00_01_10_11};
    rots[6] = '{stage: 2, cnt: 3,  a: 8'b01_10_11_00};
    rots[7] = '{stage: 1, cnt: 1,  a: 8'b10_11_00_01};

    reset_obs = '{sel: 1'b0, sen: 1'b0, busy: 1'b0, done: 1'b0, stage: 3'd0,
                  a0: 2'd0, a1: 2'd1, a2: 2'd2, a3: 2'd3};
    last_a    = 8'b00_01_10_11;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_obs("reset", 0, sample(), reset_obs);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_obs("idle_after_reset", 0, sample(), reset_obs);

    for (int i = 0; i < 4; i++) begin
      do_run(runs[i].mode, runs[i].tog, runs[i].done_n, runs[i].busy_n, 0);
      if (i == 0) begin
        for (int k = 0; k < 8; k++) begin
          check_int($sformatf("rot_s%0d_c%0d", rots[k].stage, rots[k].cnt),
                    int'(cap[rots[k].stage * 64 + rots[k].cnt]), int'(rots[k].a));
        end
      end
    end

    // Abort in stage 3, then confirm a clean restart.
    do_run(1'b0, 1'b0, 0, 0, 200);
    @(posedge clk);
    #1;
    check_obs("abort_reset", 0, sample(), reset_obs);
    rst       = 1'b0;
    last_a    = 8'b00_01_10_11;
    done_seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen++;
    end
    check_int("abort_done_after", done_seen, 0);
    check_obs("abort_idle", 0, sample(), reset_obs);
    do_run(1'b0, 1'b0, 457, 455, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/network_sel_gen.md
NETWORK_SEL_GEN -- requirements
Module: network_sel_gen

Interface
REQ-001 Parameter data_width, default 12: coefficient width of the datapath this block controls; it sets no port width here and exists only for parameter uniformity across the stage.
REQ-002 Parameter cnt_width, default 6: butterfly-cycle counter width; each stage lasts 2^cnt_width cycles.
REQ-003 Parameter stage_num, default 7: number of stages per transform; legal range 1..8.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a transform.
REQ-007 mode  input  1  transform direction: 0 = NTT, 1 = INTT; sampled with start.
REQ-008 sel  output  1  registered copy of mode, held for the whole transform.
REQ-009 sen  output  1  select-pipeline shift enable.
REQ-010 sel_a_0, sel_a_1, sel_a_2, sel_a_3  output  2 each  bank-routing selects for output lanes d0..d3.
REQ-011 stage  output  3  current stage index.
REQ-012 busy  output  1  high from the cycle after an accepted start until the cycle done is asserted.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN, FLUSH and DONE.
REQ-015 IDLE: start=1 SHALL latch mode into sel, clear cnt and stage, and transition to RUN on the next edge.
REQ-016 RUN: cnt SHALL increment by 1 each cycle.
REQ-017 RUN, cnt at all-ones and stage < stage_num-1: cnt SHALL wrap to 0 and stage SHALL increment.
REQ-018 RUN, cnt at all-ones and stage = stage_num-1: the FSM SHALL transition to FLUSH and clear the flush counter.
REQ-019 FLUSH SHALL last exactly 7 cycles when sel=0 and 13 cycles when sel=1, then transition to DONE.
REQ-020 DONE SHALL last one cycle, assert done=1, and transition to IDLE.
REQ-021 The rotation amount SHALL be rot = (cnt[1:0] + stage[1:0]) mod 4.
REQ-022 Outputs SHALL be sel_a_i = (i + rot) mod 4 for i = 0..3, registered with one-cycle latency from the cnt/stage values that produced them.
REQ-023 sel_a_0..3 SHALL therefore always form a permutation of {0,1,2,3}.
REQ-024 In FLUSH, IDLE and DONE, sel_a_0..3 SHALL hold their last RUN values.
REQ-025 sen SHALL be 1 during RUN and FLUSH and 0 in IDLE and DONE, registered with one-cycle latency, aligned with sel_a.
REQ-026 busy SHALL be 1 in RUN and FLUSH and 0 otherwise, registered.
REQ-027 start SHALL be ignored outside IDLE, including start asserted in the DONE cycle.
REQ-028 mode changes while busy=1 SHALL have no effect on sel.
REQ-029 stage SHALL hold its final value (stage_num-1) through FLUSH and DONE, and return to 0 only on the next accepted start or on reset.
REQ-030 Total transform length, from the start edge to done=1, SHALL be 1 + stage_num*2^cnt_width + flush_len + 1 cycles.

Reset
REQ-031 rst=1 SHALL force IDLE, cnt=0, stage=0, flush counter=0, sel=0, sen=0, busy=0, done=0, sel_a_0=0, sel_a_1=1, sel_a_2=2, sel_a_3=3 on the next edge.
REQ-032 rst SHALL take priority over start and over any in-progress transform; asserting it mid-RUN or mid-FLUSH aborts without a done pulse.
REQ-033 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-034 Reset: rst=1 for 2 cycles, then 0 -> all outputs at the REQ-031 values, busy=0.
REQ-035 NTT run (defaults): start=1, mode=0 -> sel=0; busy=1 for 448+7 cycles; done pulses once, exactly 457 cycles after the start edge.
REQ-036 INTT run: start=1, mode=1 -> sel=1; flush lasts 13 cycles; done is 463 cycles after the start edge.
REQ-037 Rotation pattern: at stage=1, cnt=2, the sel_a outputs one cycle later SHALL read sel_a_0..3 = 3,0,1,2. Also check the stage 0→1 boundary at cnt wrap 63→0: stage increments and rot steps from 3 to 1.
REQ-038 Stimulus: start=1 and mode toggled every cycle during RUN -> no restart, sel constant, cycle count unchanged.
REQ-039 Reset mid-run: rst=1 at stage=3 -> IDLE next cycle, no done pulse; a following start completes a full 457-cycle transform.
